pattern_detect_param: RTL and testbench
=======================================

Name: pattern_detect_param

Overview:
- Parametrised successor to the fixed-sequence Moore detector: serial bit stream in, N-bit runtime-loadable pattern with per-bit don't-care mask, selectable overlapping/non-overlapping detection.
- Adds a saturating match counter and a sticky flag, both clearable. Sits between switch/key board I/O and the LED display logic.

Parameters:
- N, 4, pattern length in bits (2..16).
- CNT_W, 8, match counter width.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- w  in  1  serial data bit.
- w_valid  in  1  w sampled only on edges where w_valid=1.
- load  in  1  capture pattern_in/mask_in; arms detector.
- pattern_in  in  N  pattern; bit N-1 = oldest (first received) bit.
- mask_in  in  N  1 = compare bit, 0 = don't care.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- clear  in  1  synchronous clear of match_count and sticky.
- match  out  1  registered one-cycle pulse per detected pattern.
- match_count  out  CNT_W  saturating count of matches.
- sticky  out  1  set on first match, held until clear/reset.
- fill  out  clog2(N+1)  valid bits accumulated toward a match, saturates at N.
- state  out  2  current FSM state (for LEDs).

Behaviour:
- Reset (reset_b=0, asynchronous, immediate): state=UNARMED, history=0, pattern=0, mask=0, fill=0, match=0, match_count=0, sticky=0. Reset mid-stream discards all history.
- States: UNARMED=2'b00, FILLING=2'b01, ARMED=2'b10; 2'b11 is illegal and recovers to UNARMED on the next edge.
- UNARMED: w ignored; match never asserts. load -> FILLING.
- Any state, load=1: pattern<=pattern_in, mask<=mask_in, history<=0, fill<=0, next state FILLING. load beats a simultaneous w_valid (that bit is discarded) and suppresses match that cycle.
- FILLING/ARMED, w_valid=1: history<={history[N-2:0],w}; fill<=min(fill+1,N). Reaching fill=N -> ARMED.
- Match condition, evaluated on the post-shift history: fill_next==N and ((hist_next ^ pattern) & mask)==0. mask=0 matches on every valid bit once fill=N.
- match is registered. It is high for exactly the one cycle after the edge that sampled the completing bit (latency 1 edge). It is low on any edge with w_valid=0.
- On a match with overlap=1: history retained, stays ARMED.
- On a match with overlap=0: history<=0, fill<=0, state->FILLING. The next match needs N fresh bits.
- overlap may change at any time; it takes effect on the next match.
- match_count increments by 1 per match and saturates at 2^CNT_W-1 (no wrap). sticky<=1 on any match.
- clear=1 has priority over a simultaneous match for match_count and sticky (both become 0). The match pulse is still emitted. clear does not affect history, fill or state.
- No combinational path from inputs to outputs.

Test Plan:
- N=4, load pattern=4'b1101, mask=4'b1111, overlap=1; stream 1,1,0,1,1,0,1 (w_valid=1 every cycle) -> match pulses after 4th and 7th bits; match_count=2, sticky=1.
- Same stream with overlap=0 -> single match after 4th bit; fill goes 0 then 3 at end; match_count=1.
- No load after reset; stream 1,1,0,1 -> match never asserts, state=00, match_count=0. Then assert reset_b=0 mid-stream with a loaded pattern and fill=2 -> all outputs 0 immediately, without waiting for a clock edge.
- Load pattern=4'b1001, mask=4'b1011; streams 1,0,0,1 and 1,1,0,1 -> each matches; 0,1,0,1 -> no match. w_valid=0 gaps between bits are ignored, with fill holding across them.
- CNT_W=2, overlap=1, pattern=4'b1111 with a continuous stream of 1s -> matches on bits 4,5,6,7; match_count goes 1,2,3,3 (saturated).
- clear asserted on the same edge as a match -> match pulses, match_count=0, sticky=0. load asserted with w_valid=1 on a completing bit -> no match, fill=0, state=FILLING.

Source files
------------

// File: rtl/pattern_detect_param.sv
// pattern_detect_param: serial pattern detector with a runtime-loadable
// N-bit pattern and per-bit compare mask, overlapping or non-overlapping
// detection, a saturating match counter and a sticky match flag.
//
// Ports:
//   clock        system clock, all state on rising edge
//   reset_b      asynchronous active-low reset
//   w, w_valid   serial data bit and its qualifier
//   load         capture pattern_in/mask_in and (re)arm the detector
//   pattern_in   pattern, bit N-1 is the oldest bit received
//   mask_in      1 = compare bit, 0 = don't care
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   clear        synchronous clear of match_count and sticky
//   match        registered one-cycle pulse per detected pattern
//   match_count  saturating match count
//   sticky       set on first match, held until clear/reset
//   fill         valid bits accumulated toward a match, saturates at N
//   state        current FSM state
module pattern_detect_param #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned FW   = $clog2(N + 1)
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             w,
    input  logic             w_valid,
    input  logic             load,
    input  logic [N-1:0]     pattern_in,
    input  logic [N-1:0]     mask_in,
    input  logic             overlap,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             sticky,
    output logic [FW-1:0]    fill,
    output logic [1:0]       state
);

    localparam logic [1:0] UNARMED = 2'b00;
    localparam logic [1:0] FILLING = 2'b01;
    localparam logic [1:0] ARMED   = 2'b10;

    logic [N-1:0]     hist_q, hist_n;
    logic [N-1:0]     pat_q, pat_n;
    logic [N-1:0]     mask_q, mask_n;
    logic [FW-1:0]    fill_n;
    logic [1:0]       state_n;
    logic             match_n;
    logic [CNT_W-1:0] cnt_n;
    logic             sticky_n;

    logic [N-1:0]     hist_shift;
    logic [FW-1:0]    fill_inc;
    logic             full_next;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state       <= UNARMED;
            hist_q      <= '0;
            pat_q       <= '0;
            mask_q      <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
            sticky      <= 1'b0;
        end else begin
            state       <= state_n;
            hist_q      <= hist_n;
            pat_q       <= pat_n;
            mask_q      <= mask_n;
            fill        <= fill_n;
            match       <= match_n;
            match_count <= cnt_n;
            sticky      <= sticky_n;
        end
    end

    // Post-shift history and fill used by the match test
    assign hist_shift = {hist_q[N-2:0], w};
    assign fill_inc   = (fill == FW'(N)) ? fill : fill + FW'(1);
    assign full_next  = (fill_inc == FW'(N));

    // Next-state, datapath and match logic
    always_comb begin
        state_n = state;
        hist_n  = hist_q;
        pat_n   = pat_q;
        mask_n  = mask_q;
        fill_n  = fill;
        match_n = 1'b0;

        if (load) begin
            // load wins over a same-cycle data bit, which is dropped
            pat_n   = pattern_in;
            mask_n  = mask_in;
            hist_n  = '0;
            fill_n  = '0;
            state_n = FILLING;
        end else begin
            case (state)
                UNARMED: ;
                FILLING, ARMED: begin
                    if (w_valid) begin
                        hist_n  = hist_shift;
                        fill_n  = fill_inc;
                        state_n = full_next ? ARMED : FILLING;
                        if (full_next && (((hist_shift ^ pat_q) & mask_q) == '0)) begin
                            match_n = 1'b1;
                            if (!overlap) begin
                                hist_n  = '0;
                                fill_n  = '0;
                                state_n = FILLING;
                            end
                        end
                    end
                end
                default: state_n = UNARMED;
            endcase
        end
    end

    // Counter and sticky flag; clear outranks a coincident match
    always_comb begin
        cnt_n    = match_count;
        sticky_n = sticky;
        if (clear) begin
            cnt_n    = '0;
            sticky_n = 1'b0;
        end else if (match_n) begin
            sticky_n = 1'b1;
            if (match_count != {CNT_W{1'b1}}) begin
                cnt_n = match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pattern_detect_param.sv
module tb_pattern_detect_param;

    logic       clock = 1'b0;
    logic       reset_b;
    logic       w, w_valid, load, overlap, clear;
    logic [3:0] pattern_in, mask_in;

    logic       match, sticky;
    logic [7:0] match_count;
    logic [2:0] fill;
    logic [1:0] state;

    logic       match2, sticky2;
    logic [1:0] match_count2;
    logic [2:0] fill2;
    logic [1:0] state2;

    always #5 clock = ~clock;

    pattern_detect_param #(.N(4), .CNT_W(8)) dut (
        .clock(clock), .reset_b(reset_b), .w(w), .w_valid(w_valid), .load(load),
        .pattern_in(pattern_in), .mask_in(mask_in), .overlap(overlap), .clear(clear),
        .match(match), .match_count(match_count), .sticky(sticky), .fill(fill), .state(state)
    );

    pattern_detect_param #(.N(4), .CNT_W(2)) dut2 (
        .clock(clock), .reset_b(reset_b), .w(w), .w_valid(w_valid), .load(load),
        .pattern_in(pattern_in), .mask_in(mask_in), .overlap(overlap), .clear(clear),
        .match(match2), .match_count(match_count2), .sticky(sticky2), .fill(fill2), .state(state2)
    );

    typedef struct {
        logic       ld;
        logic [3:0] pat;
        logic [3:0] msk;
        logic       ov;
        logic       clr;
        logic       wv;
        logic       w;
        logic       e_match;
        logic [7:0] e_cnt;
        logic       e_sticky;
        logic [2:0] e_fill;
        logic [1:0] e_state;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic ld, input logic [3:0] pat, input logic [3:0] msk,
                                input logic ov, input logic clr, input logic wv, input logic wb,
                                input logic em, input logic [7:0] ec, input logic es,
                                input logic [2:0] ef, input logic [1:0] est);
        vec_t v;
        v.ld = ld; v.pat = pat; v.msk = msk; v.ov = ov; v.clr = clr; v.wv = wv; v.w = wb;
        v.e_match = em; v.e_cnt = ec; v.e_sticky = es; v.e_fill = ef; v.e_state = est;
        vecs.push_back(v);
    endfunction

    // Data bit with w_valid=1
    function automatic void add_bit(input logic ov, input logic wb, input logic em,
                                    input logic [7:0] ec, input logic es,
                                    input logic [2:0] ef, input logic [1:0] est);
        add(1'b0, 4'b0, 4'b0, ov, 1'b0, 1'b1, wb, em, ec, es, ef, est);
    endfunction

    // Idle cycle (w_valid=0), optional clear
    function automatic void add_idle(input logic ov, input logic clr, input logic [7:0] ec,
                                     input logic es, input logic [2:0] ef, input logic [1:0] est);
        add(1'b0, 4'b0, 4'b0, ov, clr, 1'b0, 1'b1, 1'b0, ec, es, ef, est);
    endfunction

    // Load cycle, always lands in FILLING with fill=0 and no match
    function automatic void add_load(input logic [3:0] pat, input logic [3:0] msk, input logic ov,
                                     input logic [7:0] ec, input logic es);
        add(1'b1, pat, msk, ov, 1'b0, 1'b0, 1'b0, 1'b0, ec, es, 3'd0, 2'b01);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [3:0] pat, input logic [3:0] msk,
                         input logic ov, input logic clr, input logic wv, input logic wb);
        load = ld; pattern_in = pat; mask_in = msk; overlap = ov; clear = clr;
        w_valid = wv; w = wb;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int exp_cnt2 [7];
        int exp_m2   [7];
        exp_cnt2 = '{0, 0, 0, 1, 2, 3, 3};
        exp_m2   = '{0, 0, 0, 1, 1, 1, 1};

        // no load after reset: stream ignored
        add_bit(1, 1, 0, 0, 0, 0, 2'b00);
        add_bit(1, 1, 0, 0, 0, 0, 2'b00);
        add_bit(1, 0, 0, 0, 0, 0, 2'b00);
        add_bit(1, 1, 0, 0, 0, 0, 2'b00);
        // overlapping 1101 on 1,1,0,1,1,0,1
        add_load(4'b1101, 4'b1111, 1, 0, 0);
        add_bit(1, 1, 0, 0, 0, 1, 2'b01);
        add_bit(1, 1, 0, 0, 0, 2, 2'b01);
        add_bit(1, 0, 0, 0, 0, 3, 2'b01);
        add_bit(1, 1, 1, 1, 1, 4, 2'b10);
        add_bit(1, 1, 0, 1, 1, 4, 2'b10);
        add_bit(1, 0, 0, 1, 1, 4, 2'b10);
        add_bit(1, 1, 1, 2, 1, 4, 2'b10);
        add_idle(1, 0, 2, 1, 4, 2'b10);
        // non-overlapping, same stream
        add_load(4'b1101, 4'b1111, 0, 2, 1);
        add_bit(0, 1, 0, 2, 1, 1, 2'b01);
        add_bit(0, 1, 0, 2, 1, 2, 2'b01);
        add_bit(0, 0, 0, 2, 1, 3, 2'b01);
        add_bit(0, 1, 1, 3, 1, 0, 2'b01);
        add_bit(0, 1, 0, 3, 1, 1, 2'b01);
        add_bit(0, 0, 0, 3, 1, 2, 2'b01);
        add_bit(0, 1, 0, 3, 1, 3, 2'b01);
        add_idle(0, 1, 0, 0, 3, 2'b01);
        // masked pattern 1001/1011 with w_valid gaps
        add_load(4'b1001, 4'b1011, 1, 0, 0);
        add_bit(1, 1, 0, 0, 0, 1, 2'b01);
        add_idle(1, 0, 0, 0, 1, 2'b01);
        add_bit(1, 0, 0, 0, 0, 2, 2'b01);
        add_idle(1, 0, 0, 0, 2, 2'b01);
        add_bit(1, 0, 0, 0, 0, 3, 2'b01);
        add_bit(1, 1, 1, 1, 1, 4, 2'b10);
        add_bit(1, 1, 0, 1, 1, 4, 2'b10);
        add_bit(1, 1, 0, 1, 1, 4, 2'b10);
        add_bit(1, 0, 0, 1, 1, 4, 2'b10);
        add_bit(1, 1, 1, 2, 1, 4, 2'b10);
        add_bit(1, 0, 0, 2, 1, 4, 2'b10);
        add_bit(1, 1, 0, 2, 1, 4, 2'b10);
        add_bit(1, 0, 0, 2, 1, 4, 2'b10);
        add_bit(1, 1, 0, 2, 1, 4, 2'b10);
        // load on the completing bit suppresses the match
        add_load(4'b1101, 4'b1111, 1, 2, 1);
        add_bit(1, 1, 0, 2, 1, 1, 2'b01);
        add_bit(1, 1, 0, 2, 1, 2, 2'b01);
        add_bit(1, 0, 0, 2, 1, 3, 2'b01);
        add(1, 4'b1101, 4'b1111, 1, 0, 1, 1, 0, 2, 1, 0, 2'b01);
        // clear coincident with a match
        add_bit(1, 1, 0, 2, 1, 1, 2'b01);
        add_bit(1, 1, 0, 2, 1, 2, 2'b01);
        add_bit(1, 0, 0, 2, 1, 3, 2'b01);
        add(0, 4'b0, 4'b0, 1, 1, 1, 1, 1, 0, 0, 4, 2'b10);

        load = 0; pattern_in = 0; mask_in = 0; overlap = 0; clear = 0; w_valid = 0; w = 0;
        reset_b = 1'b0;
        #22;
        chk("reset_match", int'(match), 0);
        chk("reset_count", int'(match_count), 0);
        chk("reset_sticky", int'(sticky), 0);
        chk("reset_fill", int'(fill), 0);
        chk("reset_state", int'(state), 0);
        reset_b = 1'b1;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].pat, vecs[i].msk, vecs[i].ov, vecs[i].clr,
                  vecs[i].wv, vecs[i].w);
            n_vec++;
            if ({match, match_count, sticky, fill, state} !=
                {vecs[i].e_match, vecs[i].e_cnt, vecs[i].e_sticky, vecs[i].e_fill, vecs[i].e_state}) begin
                n_bad++;
                $display("FAIL vec%0d: got match=%0d cnt=%0d sticky=%0d fill=%0d state=%0d expected match=%0d cnt=%0d sticky=%0d fill=%0d state=%0d",
                         i, match, match_count, sticky, fill, state,
                         vecs[i].e_match, vecs[i].e_cnt, vecs[i].e_sticky, vecs[i].e_fill, vecs[i].e_state);
            end
        end

        // asynchronous reset mid-stream with fill=2
        drive(1, 4'b1111, 4'b1111, 1, 0, 0, 0);
        drive(0, 4'b0, 4'b0, 1, 0, 1, 1);
        drive(0, 4'b0, 4'b0, 1, 0, 1, 1);
        chk("pre_reset_fill", int'(fill), 2);
        w_valid = 0;
        #2 reset_b = 1'b0;
        #1;
        chk("async_match", int'(match), 0);
        chk("async_count", int'(match_count), 0);
        chk("async_sticky", int'(sticky), 0);
        chk("async_fill", int'(fill), 0);
        chk("async_state", int'(state), 0);
        #2 reset_b = 1'b1;
        @(posedge clock);
        #1;

        // CNT_W=2 saturation on a run of 1s
        drive(1, 4'b1111, 4'b1111, 1, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            drive(0, 4'b0, 4'b0, 1, 0, 1, 1);
            chk($sformatf("sat_match_b%0d", k + 1), int'(match2), exp_m2[k]);
            chk($sformatf("sat_count_b%0d", k + 1), int'(match_count2), exp_cnt2[k]);
        end
        drive(0, 4'b0, 4'b0, 1, 0, 0, 0);
        chk("sat_idle_match", int'(match2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
